// File: rtl/pc_fetch_pkg.sv
// pc_fetch_pkg: shared constants, state encoding and defaults for the fetch front end
//   DEF_ADDR_W / DEF_INSTR_W / DEF_RESET_PC : default widths and reset PC
//   OP_BEQ / OP_BNE                         : branch opcodes (top 4 bits of an instruction)
//   state_t                                 : fetch FSM state encoding
package pc_fetch_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INSTR_W = 16;
    localparam logic [31:0] DEF_RESET_PC = 32'd0;
    localparam logic [3:0] OP_BEQ = 4'd6;
    localparam logic [3:0] OP_BNE = 4'd7;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/pc_fetch_if.sv
// pc_fetch_if: redirect, instruction-memory and decode handshakes of the fetch unit
//   pc_load_en/pc_load_val             : redirect from the branch unit
//   imem_req/imem_addr/imem_ack/imem_rdata : word fetch handshake to instruction memory
//   if_valid/if_instr/if_pc/id_ready   : instruction handoff to decode
//   master = fetch unit, slave = surrounding system
interface pc_fetch_if
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W
);
    logic               pc_load_en;
    logic [ADDR_W-1:0]  pc_load_val;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               id_ready;

    modport master (
        input  pc_load_en, pc_load_val, imem_ack, imem_rdata, id_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc
    );

    modport slave (
        output pc_load_en, pc_load_val, imem_ack, imem_rdata, id_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc
    );
endinterface

// File: rtl/pc_reg.sv
// pc_reg: program counter with async active-low reset, load, increment and modulo wrap
//   clk, rst_n   : clock, asynchronous active-low reset (loads RESET_PC)
//   load_en_i    : load load_val_i unmodified (wins over inc_i)
//   inc_i        : advance by one, wrapping modulo 2^ADDR_W
//   pc_o         : current PC
//   pc_next_o    : PC after the coming clock edge
module pc_reg #(
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_next_o
);
    logic [ADDR_W-1:0] pc_q, pc_d;

    always_comb pc_d = load_en_i ? load_val_i : inc_i ? pc_q + ADDR_W'(1) : pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_q <= RESET_PC;
        else        pc_q <= pc_d;
    end

    assign pc_o = pc_q;
    assign pc_next_o = pc_d;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter and instruction-fetch front end, one word fetch per instruction
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pc_fetch_if.master (redirect in, imem req/ack, decode valid/ready)
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic       clk,
    input  logic       rst_n,
    pc_fetch_if.master bus
);
    state_t             state_q, state_d;
    logic               kill_q, kill_d;
    logic               req_q, req_d;
    logic               valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0]  pc, pc_next;
    logic               ack, take;

    // an ack only counts in S_REQ; it is kept only if no redirect is pending or arriving
    assign ack  = state_q == S_REQ && bus.imem_ack;
    assign take = ack && !kill_q && !bus.pc_load_en;

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_en_i  (bus.pc_load_en),
        .load_val_i (bus.pc_load_val),
        .inc_i      (take),
        .pc_o       (pc),
        .pc_next_o  (pc_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kill_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            addr_q  <= RESET_PC;
            if_pc_q <= '0;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            addr_q  <= addr_d;
            if_pc_q <= if_pc_d;
            instr_q <= instr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   state_d = take ? S_HOLD : S_REQ;
            S_HOLD:  state_d = (bus.id_ready || bus.pc_load_en) ? S_REQ : S_HOLD;
            default: state_d = S_IDLE;
        endcase
    end

    // a redirect during an unacked fetch cannot move imem_addr, so it is remembered in kill
    // and the in-flight word is thrown away when it lands
    always_comb begin
        kill_d  = state_q == S_REQ && !ack && (kill_q || bus.pc_load_en);
        req_d   = state_d == S_REQ;
        valid_d = state_d == S_HOLD;
        addr_d  = (state_q == S_REQ && !bus.imem_ack) ? addr_q : pc_next;
        if_pc_d = take ? pc : if_pc_q;
        instr_d = take ? bus.imem_rdata : instr_q;
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = instr_q;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed bench for pc_fetch with hand-computed expected values
module tb_pc_fetch;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_pass = 0;

    pc_fetch_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

    pc_fetch dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // serve one fetch: wait for req, check address stability for dly cycles, ack with data,
    // then check the presented instruction; rdy is the id_ready level while it is held
    task automatic fetch(input logic [31:0] addr, input logic [15:0] data, input int dly,
                         input logic rdy);
        for (int i = 0; i < 10 && !bus.imem_req; i++) step();
        check("req_up", 32'(bus.imem_req), 32'd1);
        check("req_addr", bus.imem_addr, addr);
        check("valid_lo_in_req", 32'(bus.if_valid), 32'd0);
        repeat (dly) begin
            step();
            check("addr_hold", bus.imem_addr, addr);
        end
        bus.imem_ack = 1'b1;
        bus.imem_rdata = data;
        bus.id_ready = rdy;
        step();
        bus.imem_ack = 1'b0;
        check("valid_hi", 32'(bus.if_valid), 32'd1);
        check("if_pc", bus.if_pc, addr);
        check("if_instr", 32'(bus.if_instr), 32'(data));
        check("req_lo_in_hold", 32'(bus.imem_req), 32'd0);
    endtask

    initial begin
        bus.pc_load_en = 1'b0;
        bus.pc_load_val = '0;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = '0;
        bus.id_ready = 1'b1;
        repeat (2) step();
        check("rst_req", 32'(bus.imem_req), 32'd0);
        check("rst_addr", bus.imem_addr, 32'd0);
        check("rst_valid", 32'(bus.if_valid), 32'd0);
        check("rst_instr", 32'(bus.if_instr), 32'd0);
        check("rst_pc", bus.if_pc, 32'd0);
        rst_n = 1'b1;
        #1 check("idle_req", 32'(bus.imem_req), 32'd0);
        step();
        check("first_req", 32'(bus.imem_req), 32'd1);

        // free run
        fetch(32'd0, 16'h1000, 1, 1'b1);
        fetch(32'd1, 16'h1001, 1, 1'b1);
        fetch(32'd2, 16'h1002, 1, 1'b1);
        fetch(32'd3, 16'h1003, 1, 1'b1);

        // back-pressure
        fetch(32'd4, 16'h6123, 1, 1'b0);
        repeat (5) begin
            step();
            check("bp_valid", 32'(bus.if_valid), 32'd1);
            check("bp_instr", 32'(bus.if_instr), 32'h6123);
            check("bp_pc", bus.if_pc, 32'd4);
            check("bp_req", 32'(bus.imem_req), 32'd0);
        end
        bus.id_ready = 1'b1;
        step();
        check("bp_valid_drop", 32'(bus.if_valid), 32'd0);
        check("bp_next_addr", bus.imem_addr, 32'd5);

        // redirect while holding, decode not ready
        fetch(32'd5, 16'h5555, 0, 1'b0);
        bus.pc_load_en = 1'b1;
        bus.pc_load_val = 32'h20;
        step();
        bus.pc_load_en = 1'b0;
        check("rd_hold_valid", 32'(bus.if_valid), 32'd0);
        check("rd_hold_req", 32'(bus.imem_req), 32'd1);
        check("rd_hold_addr", bus.imem_addr, 32'h20);
        fetch(32'h20, 16'h7020, 1, 1'b1);

        // redirect mid-fetch: steer to 7 first, then redirect while its fetch is outstanding
        bus.pc_load_en = 1'b1;
        bus.pc_load_val = 32'd7;
        step();
        check("mf_addr7", bus.imem_addr, 32'd7);
        bus.pc_load_val = 32'h40;
        step();
        bus.pc_load_en = 1'b0;
        check("mf_hold1", bus.imem_addr, 32'd7);
        step();
        check("mf_hold2", bus.imem_addr, 32'd7);
        step();
        check("mf_hold3", bus.imem_addr, 32'd7);
        check("mf_req", 32'(bus.imem_req), 32'd1);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hAAAA;
        step();
        bus.imem_ack = 1'b0;
        check("mf_discard_valid", 32'(bus.if_valid), 32'd0);
        check("mf_discard_instr", 32'(bus.if_instr), 32'h7020);
        check("mf_new_addr", bus.imem_addr, 32'h40);
        fetch(32'h40, 16'h4040, 1, 1'b1);

        // wrap
        bus.pc_load_en = 1'b1;
        bus.pc_load_val = 32'hFFFF_FFFF;
        step();
        bus.pc_load_en = 1'b0;
        fetch(32'hFFFF_FFFF, 16'hFFFF, 1, 1'b1);
        fetch(32'd0, 16'h0001, 1, 1'b1);

        // async reset mid-fetch with an ack in the same cycle
        for (int i = 0; i < 10 && !bus.imem_req; i++) step();
        check("ar_req_before", 32'(bus.imem_req), 32'd1);
        check("ar_addr_before", bus.imem_addr, 32'd1);
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 16'hBEEF;
        #2 rst_n = 1'b0;
        #1 check("ar_req_now", 32'(bus.imem_req), 32'd0);
        check("ar_valid_now", 32'(bus.if_valid), 32'd0);
        check("ar_addr_now", bus.imem_addr, 32'd0);
        step();
        bus.imem_ack = 1'b0;
        check("ar_instr", 32'(bus.if_instr), 32'd0);
        rst_n = 1'b1;
        #1 check("ar_idle_req", 32'(bus.imem_req), 32'd0);
        fetch(32'd0, 16'h1234, 1, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
